// File: rtl/data_mem_responder.sv
// MEM-stage data-memory responder: fixed-latency word RAM behind a request/stall handshake.
// The pipeline is frozen via mem_stall until a read's data is ready or a write is committed.
module data_mem_responder #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_ren,
  input  logic        mem_wen,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_dout,
  output logic [31:0] mem_din,
  output logic        mem_stall,
  output logic        mem_err,
  output logic [15:0] acc_cnt
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic [3:0]              r_cnt;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [31:0]             r_wdata;
  logic                    r_wr;
  logic                    r_oor;
  logic                    r_bad;
  logic [31:0]             r_ram [0:DEPTH-1];

  logic w_req;
  logic w_oor;
  logic w_commit;
  logic w_unused_ok;

  assign w_req       = mem_ren | mem_wen;
  assign w_oor       = |mem_addr[31:ADDR_WIDTH+2];
  assign w_commit    = (r_state == BUSY) && (r_cnt == '0);
  assign w_unused_ok = &{1'b0, mem_addr[1:0]};

  always_comb begin
    w_next    = r_state;
    mem_stall = 1'b0;
    case (r_state)
      IDLE: begin
        mem_stall = w_req;
        if (w_req) w_next = BUSY;
      end
      BUSY: begin
        mem_stall = 1'b1;
        if (r_cnt == '0) w_next = DONE;
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
    if (rst) mem_stall = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_wr    <= 1'b0;
      r_oor   <= 1'b0;
      r_bad   <= 1'b0;
      mem_din <= '0;
      mem_err <= 1'b0;
      acc_cnt <= '0;
    end else begin
      r_state <= w_next;
      mem_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_req) begin
            r_addr  <= mem_addr[ADDR_WIDTH+1:2];
            r_wdata <= mem_dout;
            r_wr    <= mem_wen;
            r_oor   <= w_oor;
            r_bad   <= w_oor | (mem_ren & mem_wen);
            r_cnt   <= 4'(LATENCY - 1);
          end
        end
        BUSY: begin
          if (r_cnt == '0) begin
            acc_cnt <= acc_cnt + 16'd1;
            mem_err <= r_bad;
            if (!r_wr) mem_din <= r_oor ? '0 : r_ram[r_addr];
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // RAM has no reset; an async reset moves the FSM out of BUSY, so no commit follows
  always_ff @(posedge clk) begin
    if (w_commit && r_wr && !r_oor) r_ram[r_addr] <= r_wdata;
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Testbench for data_mem_responder: directed scenarios plus randomized accesses
// checked against a word-level memory model.
module tb_data_mem_responder;

  localparam int unsigned AW  = 10;
  localparam int unsigned LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_ren, mem_wen;
  logic [31:0] mem_addr, mem_dout;
  logic [31:0] mem_din;
  logic        mem_stall, mem_err;
  logic [15:0] acc_cnt;

  int checks   = 0;
  int failures = 0;

  logic [31:0] mdl_mem [int];
  logic [31:0] mdl_din;
  bit          din_known;
  logic [15:0] mdl_acc;

  always #5 clk = ~clk;

  data_mem_responder #(.ADDR_WIDTH(AW), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .mem_ren(mem_ren), .mem_wen(mem_wen),
    .mem_addr(mem_addr), .mem_dout(mem_dout), .mem_din(mem_din),
    .mem_stall(mem_stall), .mem_err(mem_err), .acc_cnt(acc_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge of the following IDLE cycle.
  task automatic access(input bit ren, input bit wen, input logic [31:0] addr,
                        input logic [31:0] data, input bit scramble, input bit hold);
    bit oor;
    bit err;
    int w;
    mem_ren = ren; mem_wen = wen; mem_addr = addr; mem_dout = data;
    #1 chk("stall_accept", mem_stall, 1);
    for (int i = 0; i < LAT; i++) begin
      @(negedge clk);
      if (scramble) begin
        mem_addr = $urandom; mem_dout = $urandom;
        mem_ren = 1'($urandom); mem_wen = 1'($urandom);
      end
      #1;
      chk("stall_busy", mem_stall, 1);
      chk("err_busy", mem_err, 0);
      if (din_known) chk("din_hold_busy", mem_din, mdl_din);
    end
    oor = (addr >> (AW + 2)) != 0;
    w   = int'(addr[AW+1:2]);
    err = oor || (ren && wen);
    if (wen) begin
      if (!oor) mdl_mem[w] = data;
    end else if (oor) begin
      mdl_din = '0; din_known = 1'b1;
    end else if (mdl_mem.exists(w)) begin
      mdl_din = mdl_mem[w]; din_known = 1'b1;
    end else begin
      din_known = 1'b0;
    end
    mdl_acc++;
    @(negedge clk);
    mem_ren = ren; mem_wen = wen; mem_addr = addr; mem_dout = data;
    #1;
    chk("stall_done", mem_stall, 0);
    chk("err_done", mem_err, 32'(err));
    chk("acc_done", acc_cnt, mdl_acc);
    if (din_known) chk("din_done", mem_din, mdl_din);
    @(negedge clk);
    if (!hold) begin
      mem_ren = 1'b0; mem_wen = 1'b0;
      #1;
      chk("stall_idle", mem_stall, 0);
      chk("err_idle", mem_err, 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, d;
    int          op;
    rst = 1'b1; mem_ren = 1'b1; mem_wen = 1'b0; mem_addr = '0; mem_dout = '0;
    mdl_din = '0; din_known = 1'b1; mdl_acc = '0;
    @(negedge clk); @(negedge clk);
    #1;
    chk("rst_stall", mem_stall, 0);
    chk("rst_din", mem_din, 0);
    chk("rst_err", mem_err, 0);
    chk("rst_acc", acc_cnt, 0);
    mem_ren = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // read of unwritten word 0: timing only, then give it a known value
    access(1, 0, 32'h0, 32'h0, 0, 0);
    access(0, 1, 32'h0, 32'hA5A5_0000, 0, 0);
    access(0, 1, 32'h10, 32'hDEAD_BEEF, 0, 0);
    access(1, 0, 32'h10, 32'h0, 0, 0);
    access(0, 1, 32'h4, 32'h1111_0004, 0, 0);
    access(0, 1, 32'h8, 32'h2222_0008, 0, 0);
    // CPU holds the request straight into the next one
    access(1, 0, 32'h4, 32'h0, 0, 1);
    access(1, 0, 32'h8, 32'h0, 0, 0);
    // out-of-range read and write; 0x10000 aliases word 0 if the range check is missing
    access(1, 0, 32'h0001_0000, 32'h0, 0, 0);
    access(0, 1, 32'h0001_0000, 32'hBAD0_BAD0, 0, 0);
    access(1, 0, 32'h0, 32'h0, 0, 0);
    access(1, 0, 32'h10, 32'h0, 0, 0);
    // ren & wen together acts as a write with an error pulse
    access(1, 1, 32'h20, 32'h55, 0, 0);
    access(1, 0, 32'h20, 32'h0, 1, 0);
    access(0, 1, 32'h30, 32'hCAFE_0030, 1, 0);

    mem_wen = 1'b1; mem_addr = 32'h30; mem_dout = 32'h1234;
    @(posedge clk);
    #1 chk("stall_pre_rst", mem_stall, 1);
    rst = 1'b1;
    #1;
    chk("rst_busy_stall", mem_stall, 0);
    chk("rst_busy_din", mem_din, 0);
    chk("rst_busy_acc", acc_cnt, 0);
    mdl_acc = '0; mdl_din = '0; din_known = 1'b1;
    @(negedge clk);
    mem_wen = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    access(1, 0, 32'h30, 32'h0, 0, 0);

    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 9) == 0)
        a = {20'($urandom_range(1, 32'hF_FFFF)), 12'($urandom)};
      else
        a = {26'd0, 4'($urandom_range(0, 15)), 2'($urandom)};
      d  = $urandom;
      op = $urandom_range(0, 5);
      access(op <= 1'b0 ? 1'b1 : (op >= 3), op <= 2, a, d,
             1'($urandom), 1'($urandom));
      if ($urandom_range(0, 3) == 0) begin
        mem_ren = 1'b0; mem_wen = 1'b0;
        @(negedge clk);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
